alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter OP_AND, 4'b0000, AND encoding driven on alu_op.
REQ-003 Parameter OP_OR, 4'b0001, OR encoding.
REQ-004 Parameter OP_ADD, 4'b0010, ADD encoding.
REQ-005 Parameter OP_SUB, 4'b0110, SUB encoding.
REQ-006 Parameter OP_SLT, 4'b0111, signed set-less-than encoding.
REQ-007 Parameter OP_NOR, 4'b1100, NOR encoding.
REQ-008 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instr/operands valid this cycle
- instr  in  32  MIPS instruction word
- rs_data  in  32  register-file value of rs
- rt_data  in  32  register-file value of rt
- stall  in  1  hold all output registers
- flush  in  1  replace the stage contents with a bubble
- out_valid  out  1  registered outputs hold an issued instruction
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU operation code, encoded per REQ-002..007
- dest_reg  out  5  write-back register index
- reg_write  out  1  write-back enable
- illegal  out  1  captured instruction is unsupported
- illegal_cnt  out  8  saturating count of illegal instructions captured

Function
REQ-009 Decode SHALL use opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm = [15:0].
REQ-010 For opcode 0x00, funct SHALL select the operation: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
- b = rt_data, dest = rd, reg_write = 1.
REQ-011 addi (0x08) and slti (0x0A) SHALL drive ADD/SLT with b = sign-extended imm, dest = rt, reg_write = 1.
REQ-012 andi (0x0C) and ori (0x0D) SHALL drive AND/OR with b = zero-extended imm, dest = rt, reg_write = 1.
REQ-013 Memory and branch instructions SHALL decode as follows:
- lw (0x23): ADD, sign-extended imm, dest = rt, reg_write = 1.
- sw (0x2B): ADD, sign-extended imm, reg_write = 0.
- beq (0x04): SUB, b = rt_data, reg_write = 0.
REQ-014 For every decoded instruction, a SHALL equal rs_data.
REQ-015 instr == 32'h0 (nop) SHALL issue out_valid = 1, alu_op = OP_AND, reg_write = 0, illegal = 0.
REQ-016 Any other opcode/funct, including a nonzero instr with opcode 0 and an unlisted funct, SHALL issue:
- out_valid = 1, illegal = 1, alu_op = OP_AND, reg_write = 0, a = b = 0, dest = 0.
REQ-017 All outputs SHALL be registered, with a latency of 1 cycle from capture.
REQ-018 Per-edge priority SHALL be rst > flush > stall > capture.
REQ-019 Flush SHALL force out_valid, reg_write and illegal to 0 and all data outputs to 0; flush SHALL win over a simultaneous stall.
REQ-020 Stall SHALL hold every output, including illegal_cnt, unchanged; an input presented during stall is dropped, and the upstream stage holds it.
REQ-021 With no stall or flush, in_valid = 0 SHALL load a bubble: out_valid = 0, reg_write = 0, illegal = 0.
REQ-022 illegal_cnt SHALL increment by 1 on each edge that captures an illegal instruction, saturating at 255 with no wrap.
REQ-023 Unused dest bits and operand bits SHALL never be X after reset.

Reset
REQ-024 On an edge with rst = 1, all outputs SHALL become 0 (illegal_cnt = 0), regardless of stall, flush or in_valid.
REQ-025 A reset asserted mid-stall SHALL discard the held instruction; the first capture is allowed on the first edge after rst deasserts.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- instr 0x00221820 (add $3,$1,$2), rs = 5, rt = 7 -> next cycle alu_op 0010, a 5, b 7, dest 3, reg_write 1.
- instr 0x2022FFFF (addi $2,$1,-1) -> b 0xFFFFFFFF, op 0010, dest 2.
- instr 0x34228000 (ori) -> b 0x00008000, op 0001.
- Capture, then stall 3 cycles with changing instr -> outputs unchanged; assert flush+stall together -> out_valid 0.
- 256 illegal instrs (0xFC000000), then one more -> illegal_cnt stays 255; rst -> 0.
- instr 0x00000000 -> out_valid 1, reg_write 0, illegal 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Decode a MIPS ALU/memory/branch instruction into registered ALU issue controls.
// Latency: one cycle from capture to outputs; illegal encodings issue as marked no-ops.
// Backpressure: stall freezes every output register and the upstream stage holds its input.
module alu_issue_stage #(
  parameter logic [3:0] OP_AND = 4'b0000,
  parameter logic [3:0] OP_OR  = 4'b0001,
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_SUB = 4'b0110,
  parameter logic [3:0] OP_SLT = 4'b0111,
  parameter logic [3:0] OP_NOR = 4'b1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rt_idx   = instr[20:16];
  assign rd_idx   = instr[15:11];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  logic        dec_illegal;
  logic        dec_wr;
  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_dest;

  always_comb begin
    dec_illegal = 1'b0;
    dec_wr      = 1'b0;
    dec_op      = OP_AND;
    dec_a       = rs_data;
    dec_b       = 32'h0;
    dec_dest    = 5'd0;
    // All-zero word is the canonical nop: the defaults above already describe it.
    if (instr != 32'h0) begin
      case (opcode)
        6'h00: begin
          dec_b    = rt_data;
          dec_dest = rd_idx;
          dec_wr   = 1'b1;
          case (funct)
            6'h20:   dec_op = OP_ADD;
            6'h22:   dec_op = OP_SUB;
            6'h24:   dec_op = OP_AND;
            6'h25:   dec_op = OP_OR;
            6'h27:   dec_op = OP_NOR;
            6'h2A:   dec_op = OP_SLT;
            default: dec_illegal = 1'b1;
          endcase
        end
        6'h08: begin dec_op = OP_ADD; dec_b = imm_sext; dec_dest = rt_idx; dec_wr = 1'b1; end
        6'h0A: begin dec_op = OP_SLT; dec_b = imm_sext; dec_dest = rt_idx; dec_wr = 1'b1; end
        6'h0C: begin dec_op = OP_AND; dec_b = imm_zext; dec_dest = rt_idx; dec_wr = 1'b1; end
        6'h0D: begin dec_op = OP_OR;  dec_b = imm_zext; dec_dest = rt_idx; dec_wr = 1'b1; end
        6'h23: begin dec_op = OP_ADD; dec_b = imm_sext; dec_dest = rt_idx; dec_wr = 1'b1; end
        6'h2B: begin dec_op = OP_ADD; dec_b = imm_sext; end
        6'h04: begin dec_op = OP_SUB; dec_b = rt_data; end
        default: dec_illegal = 1'b1;
      endcase
    end
    if (dec_illegal) begin
      dec_wr   = 1'b0;
      dec_op   = OP_AND;
      dec_a    = 32'h0;
      dec_b    = 32'h0;
      dec_dest = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= 32'h0;
      alu_b       <= 32'h0;
      alu_op      <= OP_AND;
      dest_reg    <= 5'd0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= 8'd0;
    end else if (flush) begin
      // The illegal count is history, not stage contents, so a flush keeps it.
      out_valid <= 1'b0;
      alu_a     <= 32'h0;
      alu_b     <= 32'h0;
      alu_op    <= OP_AND;
      dest_reg  <= 5'd0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        out_valid <= 1'b1;
        alu_a     <= dec_a;
        alu_b     <= dec_b;
        alu_op    <= dec_op;
        dest_reg  <= dec_dest;
        reg_write <= dec_wr;
        illegal   <= dec_illegal;
        if (dec_illegal && illegal_cnt != 8'hFF) begin
          illegal_cnt <= illegal_cnt + 8'd1;
        end
      end else begin
        out_valid <= 1'b0;
        alu_a     <= 32'h0;
        alu_b     <= 32'h0;
        alu_op    <= OP_AND;
        dest_reg  <= 5'd0;
        reg_write <= 1'b0;
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic vs a decode-table model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .dest_reg(dest_reg), .reg_write(reg_write), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic        wr;
    logic        ill;
  } exp_t;

  exp_t got;
  assign got = {out_valid, alu_a, alu_b, alu_op, dest_reg, reg_write, illegal};

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: r is the expected issue, m marks which fields the behaviour pins down.
  function automatic void decode(input logic [31:0] i, input logic [31:0] ra,
                                 input logic [31:0] rb, output exp_t r, output exp_t m);
    int opc = int'(i[31:26]);
    int fn  = int'(i[5:0]);
    logic [31:0] simm = 32'($signed(i[15:0]));
    logic [31:0] zimm = 32'(i[15:0]);
    r = '0;
    m = '1;
    r.v = 1'b1;
    if (i == 32'h0) begin
      r.a = ra; m.b = '0; m.dest = '0;
    end else if (opc == 0 && fn inside {32, 34, 36, 37, 39, 42}) begin
      r.a = ra; r.b = rb; r.dest = i[15:11]; r.wr = 1'b1;
      r.op = (fn == 32) ? 4'b0010 : (fn == 34) ? 4'b0110 : (fn == 36) ? 4'b0000 :
             (fn == 37) ? 4'b0001 : (fn == 39) ? 4'b1100 : 4'b0111;
    end else if (opc inside {8, 10, 12, 13, 35}) begin
      r.a = ra; r.dest = i[20:16]; r.wr = 1'b1;
      r.b  = (opc == 12 || opc == 13) ? zimm : simm;
      r.op = (opc == 10) ? 4'b0111 : (opc == 12) ? 4'b0000 : (opc == 13) ? 4'b0001 : 4'b0010;
    end else if (opc == 43) begin
      r.a = ra; r.b = simm; r.op = 4'b0010; m.dest = '0;
    end else if (opc == 4) begin
      r.a = ra; r.b = rb; r.op = 4'b0110; m.dest = '0;
    end else begin
      r.ill = 1'b1;
    end
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] ops [7] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 4))
      0: begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 5)]; end
      1, 2: w[31:26] = ops[$urandom_range(0, 6)];
      3: w = 32'h0;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; stall = 1'b1; flush = 1'b1;
    instr = 32'hFC000000; rs_data = $urandom; rt_data = $urandom;
    tick();
    checks++;
    if (got !== '0 || illegal_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset got %h cnt %0d required %h cnt 0", got, illegal_cnt, exp_t'('0));
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    exp_t e, m;
    logic [31:0] words [5] = '{32'h00221820, 32'h2022FFFF, 32'h34228000, 32'h00000000, 32'h00221821};
    string names [5] = '{"add", "addi", "ori", "nop", "r_unlisted"};
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; instr = words[k]; rs_data = 32'd5; rt_data = 32'd7;
      tick();
      m = '1;
      case (k)
        0: e = '{v:1'b1, a:32'd5, b:32'd7, op:4'b0010, dest:5'd3, wr:1'b1, ill:1'b0};
        1: e = '{v:1'b1, a:32'd5, b:32'hFFFFFFFF, op:4'b0010, dest:5'd2, wr:1'b1, ill:1'b0};
        2: e = '{v:1'b1, a:32'd5, b:32'h00008000, op:4'b0001, dest:5'd2, wr:1'b1, ill:1'b0};
        3: begin
          e = '{v:1'b1, a:32'd5, b:32'd0, op:4'b0000, dest:5'd0, wr:1'b0, ill:1'b0};
          m.b = '0; m.dest = '0;
        end
        default: e = '{v:1'b1, a:32'd0, b:32'd0, op:4'b0000, dest:5'd0, wr:1'b0, ill:1'b1};
      endcase
      checks++;
      if ((got & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s got %h required %h (mask %h)", names[k], got, e, m);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || reg_write !== 1'b0 || illegal !== 1'b0 || illegal_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bubble got v%b w%b i%b cnt %0d required 0 0 0 cnt 1",
               out_valid, reg_write, illegal, illegal_cnt);
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7;
    tick();
    e = '{v:1'b1, a:32'd5, b:32'd7, op:4'b0010, dest:5'd3, wr:1'b1, ill:1'b0};
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      instr = (k == 1) ? 32'hFC000000 : gen_instr();
      rs_data = $urandom; rt_data = $urandom;
      tick();
      checks++;
      if (got !== e || illegal_cnt !== 8'd0) begin
        errors++;
        $display("FAIL stall_hold%0d got %h cnt %0d required %h cnt 0", k, got, illegal_cnt, e);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL flush_over_stall got %h required %h", got, exp_t'('0));
    end
    flush = 1'b0;
    stall = 1'b0;
    instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7;
    tick();
    stall = 1'b1; rst = 1'b1; instr = 32'h2022FFFF;
    tick();
    checks++;
    if (got !== '0 || illegal_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_stall got %h cnt %0d required all zero", got, illegal_cnt);
    end
    rst = 1'b0; stall = 1'b0; instr = 32'h34228000;
    tick();
    e = '{v:1'b1, a:32'd5, b:32'h00008000, op:4'b0001, dest:5'd2, wr:1'b1, ill:1'b0};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL first_after_reset got %h required %h", got, e);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal_saturate();
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; instr = 32'hFC000000;
    tick();
    checks++;
    if (illegal_cnt !== 8'd1 || illegal !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal_first got cnt %0d ill %b v %b required 1 1 1", illegal_cnt, illegal, out_valid);
    end
    for (int k = 1; k < 256; k++) tick();
    checks++;
    if (illegal_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_256 got %0d required 255", illegal_cnt);
    end
    tick();
    checks++;
    if (illegal_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_257 got %0d required 255", illegal_cnt);
    end
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (illegal_cnt !== 8'd0) begin
      errors++;
      $display("FAIL illegal_cnt_reset got %0d required 0", illegal_cnt);
    end
  endtask

  task automatic test_random();
    exp_t e = '0;
    exp_t m = '1;
    int unsigned cnt = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      instr    = gen_instr();
      rs_data  = $urandom;
      rt_data  = $urandom;
      if (!stall) begin
        if (in_valid) begin
          decode(instr, rs_data, rt_data, e, m);
          if (e.ill && cnt < 255) cnt++;
        end else begin
          e = '0; m = '0; m.v = 1'b1; m.wr = 1'b1; m.ill = 1'b1;
        end
      end
      tick();
      checks++;
      if ((got & m) !== (e & m) || illegal_cnt !== 8'(cnt)) begin
        errors++;
        $display("FAIL random%0d instr %h got %h cnt %0d required %h cnt %0d (mask %h)",
                 n, instr, got, illegal_cnt, e, cnt, m);
      end
    end
    stall = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_flush();
    test_illegal_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
